// File: rtl/bram_flush_pkg.sv
// Shared types and helpers for the BRAM flush controller.
// State encoding is fixed so other tiles can decode it.
package bram_flush_pkg;

    typedef enum logic [1:0] {
        FLUSH_ST_IDLE  = 2'd0,
        FLUSH_ST_FLUSH = 2'd1,
        FLUSH_ST_DONE  = 2'd2
    } flush_state_e;

    // True when addr is the final word of a DEPTH-word memory.
    function automatic logic is_last_addr(input logic [31:0] addr, input int unsigned depth);
        return addr == 32'(depth - 1);
    endfunction

endpackage

// File: rtl/bram_flush_addr_cnt.sv
// Flush address counter: clears to 0, advances on enable, flags DEPTH-1.
module bram_flush_addr_cnt
    import bram_flush_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = is_last_addr(32'(count_q), DEPTH);

endmodule

// File: rtl/bram_flush_ctrl.sv
// BRAM write-port arbiter: passes user writes through when idle and
// overwrites every word with FLUSH_VALUE on request or after reset.
module bram_flush_ctrl
    import bram_flush_pkg::*;
#(
    parameter int unsigned            DEPTH          = 1024,
    parameter int unsigned            ADDR_WIDTH     = 10,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]  FLUSH_VALUE    = '0,
    parameter bit                     FLUSH_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  flush_en,
    input  logic                  flush_req,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_addr,
    input  logic [DATA_WIDTH-1:0] usr_wdata,
    output logic                  usr_ready,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  busy,
    output logic                  done
);

    flush_state_e          state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic                  cnt_clr, cnt_en, cnt_last;
    logic [ADDR_WIDTH-1:0] cnt;

    bram_flush_addr_cnt #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk    (clk),
        .resetb (resetb),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (cnt),
        .last   (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = (state_q == FLUSH_ST_DONE);
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            FLUSH_ST_IDLE: begin
                // The user write offered on the start cycle is still issued.
                we_d    = usr_we;
                addr_d  = usr_addr;
                wdata_d = usr_wdata;
                cnt_clr = 1'b1;
                if (flush_en && (flush_req || pend_q)) begin
                    state_d = FLUSH_ST_FLUSH;
                    pend_d  = 1'b0;
                end
            end
            FLUSH_ST_FLUSH: begin
                if (!flush_en) begin
                    state_d = FLUSH_ST_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = cnt;
                    wdata_d = FLUSH_VALUE;
                    cnt_en  = !cnt_last;
                    if (cnt_last) begin
                        state_d = FLUSH_ST_DONE;
                    end
                end
            end
            FLUSH_ST_DONE: begin
                state_d = FLUSH_ST_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = FLUSH_ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= FLUSH_ST_IDLE;
            pend_q  <= FLUSH_ON_RESET;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign usr_ready  = (state_q == FLUSH_ST_IDLE);
    // DONE is the cycle the last flush write sits on the bus, so it counts as busy.
    assign busy       = (state_q != FLUSH_ST_IDLE);
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bram_flush_ctrl.sv
// Self-checking bench for bram_flush_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_bram_flush_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam logic [DW-1:0] FV  = '0;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          flush_en = 1'b1;
    logic          flush_req = 1'b0;
    logic          usr_we = 1'b0;
    logic [AW-1:0] usr_addr = '0;
    logic [DW-1:0] usr_wdata = '0;
    logic          usr_ready, bram_we, busy, done;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;

    always #5 clk = ~clk;

    bram_flush_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .FLUSH_VALUE    (FV),
        .FLUSH_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .flush_en   (flush_en),
        .flush_req  (flush_req),
        .usr_we     (usr_we),
        .usr_addr   (usr_addr),
        .usr_wdata  (usr_wdata),
        .usr_ready  (usr_ready),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = flushing word m_idx, 2 = last word issued.
    int            m_mode = 0;
    int            m_idx  = 0;
    bit            m_pend = 1'b1;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_done = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge resetb);
            if (!resetb) begin
                m_mode = 0; m_idx = 0; m_pend = 1'b1;
                e_we = 1'b0; e_addr = '0; e_wdata = '0; e_done = 1'b0;
            end else begin
                e_done = (m_mode == 2);
                e_we   = 1'b0;
                case (m_mode)
                    0: begin
                        e_we = usr_we; e_addr = usr_addr; e_wdata = usr_wdata;
                        if (flush_en && (flush_req || m_pend)) begin
                            m_mode = 1; m_idx = 0; m_pend = 1'b0;
                        end
                    end
                    1: begin
                        if (!flush_en) begin
                            m_mode = 0;
                        end else begin
                            e_we = 1'b1; e_addr = AW'(m_idx); e_wdata = FV;
                            if (m_idx == DEPTH - 1) m_mode = 2;
                            else m_idx++;
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
        end
    end

    // Single compare process, sampling mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (resetb) begin
                check("bram_we", bram_we, e_we);
                if (e_we) begin
                    check("bram_addr", bram_addr, e_addr);
                    check("bram_wdata", bram_wdata, e_wdata);
                end
                check("usr_ready", usr_ready, m_mode == 0);
                check("busy", busy, m_mode != 0);
                check("done", done, e_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, bram_we, 1'b0);
        check({tag, "_addr"}, bram_addr, '0);
        check({tag, "_wdata"}, bram_wdata, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ready"}, usr_ready, 1'b1);
    endtask

    int w, nd, nr, done_cyc, first_a, last_a;
    bit found;

    initial begin
        // Power-on flush after reset release.
        tick(); tick();
        check_reset_outputs("rst");
        resetb = 1'b1;
        w = 0; nd = 0; done_cyc = 0; first_a = -1; last_a = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bram_we) begin
                if (w == 0) first_a = int'(bram_addr);
                last_a = int'(bram_addr);
                w++;
            end
            if (done) begin
                nd++;
                if (done_cyc == 0) done_cyc = c;
            end
        end
        check("por_writes", w, 16);
        check("por_first_addr", first_a, 0);
        check("por_last_addr", last_a, 15);
        check("por_done_cycle", done_cyc, 18);
        check("por_done_count", nd, 1);
        check("por_busy_after", busy, 1'b0);

        // Plain user write in idle.
        usr_we = 1'b1; usr_addr = 4'd5; usr_wdata = 32'hDEADBEEF;
        tick();
        usr_we = 1'b0;
        check("usr_we", bram_we, 1'b1);
        check("usr_addr", bram_addr, 4'd5);
        check("usr_wdata", bram_wdata, 32'hDEADBEEF);
        check("usr_ready_idle", usr_ready, 1'b1);

        // Flush request together with a user write.
        usr_we = 1'b1; usr_addr = 4'd3; usr_wdata = 32'h12345678; flush_req = 1'b1;
        tick();
        usr_we = 1'b0; flush_req = 1'b0;
        check("req_usr_we", bram_we, 1'b1);
        check("req_usr_addr", bram_addr, 4'd3);
        nr = 0; w = 0;
        for (int i = 0; i < 40 && !usr_ready; i++) begin
            nr++;
            if (i > 0 && bram_we) w++;
            tick();
        end
        check("req_not_ready_cycles", nr, 17);
        check("req_flush_writes", w, 16);
        check("req_done", done, 1'b1);

        // Abort after 6 flush writes.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        w = 0; last_a = -1;
        for (int i = 0; i < 20 && w < 6; i++) begin
            tick();
            if (bram_we) begin w++; last_a = int'(bram_addr); end
        end
        check("abort_writes", w, 6);
        check("abort_last_addr", last_a, 5);
        flush_en = 1'b0;
        tick();
        check("abort_we", bram_we, 1'b0);
        check("abort_ready", usr_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);

        // Request with flush disabled, then requests during a flush.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("dis_busy", busy, 1'b0);
        check("dis_we", bram_we, 1'b0);
        flush_en = 1'b1;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        w = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            flush_req = busy && (i % 3 == 0);
            tick();
            if (bram_we) w++;
            if (done) nd++;
        end
        flush_req = 1'b0;
        check("ign_writes", w, 16);
        check("ign_done_count", nd, 1);

        // Reset while the flush is at address 9.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bram_we && bram_addr == 4'd9) found = 1'b1;
        end
        check("mid_reached_9", found, 1'b1);
        resetb = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick(); tick();
        resetb = 1'b1;
        tick();
        tick();
        check("restart_we", bram_we, 1'b1);
        check("restart_addr", bram_addr, 4'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (done) found = 1'b1;
        end
        check("restart_done", found, 1'b1);

        // Random traffic with occasional requests and enable drops.
        for (int i = 0; i < 3000; i++) begin
            usr_we    = 1'($urandom_range(0, 1));
            usr_addr  = AW'($urandom_range(0, DEPTH - 1));
            usr_wdata = $urandom;
            flush_req = ($urandom_range(0, 15) == 0);
            flush_en  = ($urandom_range(0, 63) != 0);
            tick();
        end
        usr_we = 1'b0; flush_req = 1'b0; flush_en = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_flush_ctrl.md
Name: bram_flush_ctrl

Overview:
- Consumer end of the BRAM flush_opt path: takes the flush-enable level driven by the flush_opt logic tile plus a flush request, then walks every BRAM word, writing FLUSH_VALUE.
- Sits between the user write port of the logical BRAM tile and the physical BRAM macro.
- Arbitrates the write port: user traffic passes through when idle and is stalled while a flush runs.

Parameters:
- DEPTH, 1024, number of BRAM words; any value >= 2, power of two not required.
- ADDR_WIDTH, 10, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DATA_WIDTH, 32, word width.
- FLUSH_VALUE, 0, word written to every location (DATA_WIDTH bits).
- FLUSH_ON_RESET, 1, 1 = start a flush automatically on the first clock after reset release when flush_en=1.

Ports:
- clk  input  1  fabric clock; all state on rising edge.
- resetb  input  1  asynchronous active-low reset.
- flush_en  input  1  static flush option level from the flush_opt tile; 0 disables all flush activity.
- flush_req  input  1  single-cycle flush request; sampled only in IDLE.
- usr_we  input  1  user write strobe.
- usr_addr  input  ADDR_WIDTH  user write address.
- usr_wdata  input  DATA_WIDTH  user write data.
- usr_ready  output  1  1 = user write accepted this cycle.
- bram_we  output  1  registered write enable to the BRAM.
- bram_addr  output  ADDR_WIDTH  registered write address.
- bram_wdata  output  DATA_WIDTH  registered write data.
- busy  output  1  1 while in FLUSH.
- done  output  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (resetb=0, asynchronous):
  - state=IDLE, counter=0.
  - bram_we=0, bram_addr=0, bram_wdata=0, busy=0, done=0.
  - usr_ready is combinational (1 when state=IDLE), so it reads 1.
- States: IDLE, FLUSH, DONE. State is encoded as registers.
- IDLE:
  - usr_ready=1.
  - Next cycle: bram_we<=usr_we, bram_addr<=usr_addr, bram_wdata<=usr_wdata (1-cycle latency).
  - IDLE->FLUSH when flush_en=1 and flush_req=1.
  - IDLE->FLUSH also on the first cycle after reset release when FLUSH_ON_RESET=1 and flush_en=1. This is tracked by a one-shot pending flag that is set by reset and cleared on that transition.
  - On the transition counter<=0. The user write presented that same cycle is still accepted and issued; the flush starts the following cycle.
- FLUSH:
  - usr_ready=0; user writes are not accepted and must be held by the source.
  - Each cycle: bram_we<=1, bram_addr<=counter, bram_wdata<=FLUSH_VALUE, counter<=counter+1.
  - Exactly DEPTH writes, addresses 0..DEPTH-1 ascending; counter never reaches DEPTH on the bus.
  - After the write of DEPTH-1 is issued: FLUSH->DONE.
  - busy=1 from the first FLUSH cycle through the cycle bram_we carries address DEPTH-1.
- DONE:
  - bram_we<=0, done=1 for exactly one cycle, usr_ready=0, then ->IDLE.
  - Total latency from flush_req to done = DEPTH+2 cycles.
- Abort: flush_en falling to 0 while in FLUSH:
  - Next cycle ->IDLE with bram_we=0, busy=0, counter=0.
  - No done pulse. Locations already written stay flushed.
- flush_req in FLUSH or DONE: ignored, not queued.
- flush_req with flush_en=0: ignored.
- Reset mid-flush: immediate return to reset values. With FLUSH_ON_RESET=1 and flush_en=1, the flush restarts from address 0 after release.
- Counter width: ADDR_WIDTH, compared against DEPTH-1. No wrap-around occurs for non-power-of-two DEPTH.

Decomposition:
- Shared package bram_flush_pkg:
  - state enum constants FLUSH_ST_IDLE=2'd0, FLUSH_ST_FLUSH=2'd1, FLUSH_ST_DONE=2'd2.
  - helper function for the last-address compare.
- One sub-module: bram_flush_addr_cnt. It is the ADDR_WIDTH counter with clear, enable, and a terminal flag at DEPTH-1.
- Write-port mux and FSM stay in the top.

Test Plan:
- Reset then release with DEPTH=16, FLUSH_ON_RESET=1, flush_en=1 -> bram_we=1 for 16 consecutive cycles at addresses 0..15 with data 0; done pulses once at cycle 18; busy=0 afterwards.
- IDLE user write usr_we=1, addr=5, data=0xDEADBEEF -> next cycle bram_we=1, bram_addr=5, bram_wdata=0xDEADBEEF, usr_ready=1 throughout.
- flush_req while usr_we=1 addr=3 -> addr 3 user write issued first, then flush addresses 0..15; usr_ready=0 for 17 cycles.
- flush_en dropped after 6 flush writes -> addresses 0..5 written, no done pulse, IDLE next cycle, usr_ready=1.
- flush_req pulsed during FLUSH and with flush_en=0 -> no restart, exactly 16 writes, single done.
- resetb asserted at flush address 9 -> outputs 0 asynchronously; after release a fresh flush starts at address 0.
